// File: rtl/bcd_to_bin_reader.sv
// rtl/bcd_to_bin_reader.sv - snapshot a decimal digit bus and convert it to binary, MSD first
// Optional ERR_CHECK_EN: flag out-of-range digits and force bin_out to zero.
module bcd_to_bin_reader #(
  parameter int NDIG = 9,
  parameter int DIGW = 5,
  parameter int OUTW = 30
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NDIG*DIGW-1:0] digits,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUTW-1:0]      bin_out,
  output logic                 err
);

  localparam int IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [IDXW-1:0] IDX_MSD = IDXW'(NDIG - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [NDIG*DIGW-1:0] r_snap;
  logic [IDXW-1:0]      r_idx;
  logic [OUTW-1:0]      r_acc;
  logic [OUTW-1:0]      r_bin;
  logic                 r_out_valid;
  logic                 r_err;

  logic [DIGW-1:0]      w_dig [NDIG];
  logic [3:0]           w_cur_val;
  logic [OUTW-1:0]      w_acc_nxt;
  logic                 w_last;
  logic                 w_accept;
  logic                 w_handshake;
  logic                 w_err_fin;

  genvar g;
  for (g = 0; g < NDIG; g++) begin : g_dig
    assign w_dig[g] = r_snap[g*DIGW +: DIGW];
  end

  assign w_cur_val   = w_dig[r_idx][3:0];
  // acc*10 built from two shifts so no multiplier is inferred
  assign w_acc_nxt   = (r_acc << 3) + (r_acc << 1) + {{(OUTW-4){1'b0}}, w_cur_val};
  assign w_last      = (r_idx == '0);
  assign w_accept    = (r_state == S_IDLE) && in_valid;
  assign w_handshake = (r_state == S_DONE) && out_ready;

`ifdef ERR_CHECK_EN
  logic            r_err_acc;
  logic [DIGW-5:0] w_cur_hi;
  logic            w_cur_bad;

  assign w_cur_hi  = w_dig[r_idx][DIGW-1:4];
  assign w_cur_bad = (w_cur_val > 4'd9) || (|w_cur_hi);
  assign w_err_fin = r_err_acc | w_cur_bad;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_err_acc <= 1'b0;
    end else if (w_accept) begin
      r_err_acc <= 1'b0;
    end else if (r_state == S_CONV) begin
      r_err_acc <= w_err_fin;
    end
  end
`else
  logic [NDIG-1:0] w_unused_hi;

  for (g = 0; g < NDIG; g++) begin : g_unused
    assign w_unused_hi[g] = |w_dig[g][DIGW-1:4];
  end

  assign w_err_fin = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (in_valid)    w_state_nxt = S_CONV;
      S_CONV:  if (w_last)      w_state_nxt = S_DONE;
      S_DONE:  if (w_handshake) w_state_nxt = S_IDLE;
      default:                  w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (r_state == S_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_snap      <= '0;
      r_idx       <= IDX_MSD;
      r_acc       <= '0;
      r_bin       <= '0;
      r_out_valid <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_snap <= digits;
            r_acc  <= '0;
            r_idx  <= IDX_MSD;
          end
        end
        S_CONV: begin
          r_acc <= w_acc_nxt;
          r_idx <= r_idx - 1'b1;
          if (w_last) begin
            r_out_valid <= 1'b1;
            r_bin       <= w_err_fin ? '0 : w_acc_nxt;
            r_err       <= w_err_fin;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign bin_out   = r_bin;
  assign err       = r_err;

endmodule

// File: tb/tb_bcd_to_bin_reader.sv
// tb/tb_bcd_to_bin_reader.sv - directed and randomized checks of bcd_to_bin_reader against a reference model
// Honours ERR_CHECK_EN the same way as the design.
`timescale 1ns/1ps
module tb_bcd_to_bin_reader;

  localparam int NDIG = 9;
  localparam int DIGW = 5;
  localparam int OUTW = 30;
  localparam int BW   = NDIG*DIGW;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b1;
  logic [BW-1:0] digits = '0;
  logic          in_ready;
  logic          out_valid;
  logic          err;
  logic [OUTW-1:0] bin_out;

  int n_chk = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  bcd_to_bin_reader #(.NDIG(NDIG), .DIGW(DIGW), .OUTW(OUTW)) dut (
    .CLK(CLK),
    .RST(RST),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .digits(digits),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .bin_out(bin_out),
    .err(err)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [BW-1:0] dec_bus(input longint v);
    logic [BW-1:0] b;
    longint x;
    b = '0;
    x = v;
    for (int k = 0; k < NDIG; k++) begin
      b[k*DIGW +: DIGW] = DIGW'(x % 10);
      x = x / 10;
    end
    return b;
  endfunction

  // positional-weight sum: digit k weighs 10^k, truncated to OUTW bits
  function automatic logic [OUTW-1:0] ref_val(input logic [BW-1:0] b);
    longint s;
    longint p;
    s = 0;
    p = 1;
    for (int k = 0; k < NDIG; k++) begin
      s = s + longint'(b[k*DIGW +: 4]) * p;
      p = p * 10;
    end
    return s[OUTW-1:0];
  endfunction

  function automatic bit ref_bad(input logic [BW-1:0] b);
    bit bad;
    bad = 1'b0;
    for (int k = 0; k < NDIG; k++) begin
      if (b[k*DIGW +: 4] > 4'd9 || b[k*DIGW+4 +: DIGW-4] != '0) bad = 1'b1;
    end
    return bad;
  endfunction

  function automatic bit exp_err(input logic [BW-1:0] b);
`ifdef ERR_CHECK_EN
    return ref_bad(b);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [OUTW-1:0] exp_bin(input logic [BW-1:0] b);
    return exp_err(b) ? '0 : ref_val(b);
  endfunction

  function automatic logic [BW-1:0] rand_bus();
    logic [BW-1:0] b;
    for (int k = 0; k < NDIG; k++) begin
      if ($urandom_range(0, 9) != 0) b[k*DIGW +: DIGW] = DIGW'($urandom_range(0, 9));
      else                           b[k*DIGW +: DIGW] = DIGW'($urandom);
    end
    return b;
  endfunction

  // transaction-level model: idle / converting for NDIG edges / holding result
  bit              chk_en = 1'b0;
  bit              m_idle = 1'b1;
  bit              m_ov = 1'b0;
  int              m_cnt = 0;
  logic [OUTW-1:0] m_bin = '0;
  bit              m_err = 1'b0;
  logic [OUTW-1:0] m_pend_bin = '0;
  bit              m_pend_err = 1'b0;

  always @(posedge CLK) begin
    if (RST) begin
      chk_en <= 1'b1;
      m_idle <= 1'b1;
      m_ov   <= 1'b0;
      m_cnt  <= 0;
      m_bin  <= '0;
      m_err  <= 1'b0;
    end else if (chk_en) begin
      if (m_idle) begin
        if (in_valid) begin
          m_idle     <= 1'b0;
          m_cnt      <= NDIG;
          m_pend_bin <= exp_bin(digits);
          m_pend_err <= exp_err(digits);
        end
      end else if (m_cnt > 0) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          m_ov  <= 1'b1;
          m_bin <= m_pend_bin;
          m_err <= m_pend_err;
        end
      end else if (out_ready) begin
        m_ov   <= 1'b0;
        m_idle <= 1'b1;
      end
    end
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      chk("cmp_in_ready", in_ready, m_idle);
      chk("cmp_out_valid", out_valid, m_ov);
      chk("cmp_bin_out", bin_out, m_bin);
      chk("cmp_err", err, m_err);
    end
  end

  task automatic send(input logic [BW-1:0] b);
    int t;
    t = 0;
    while (!in_ready && t < 100) begin
      @(negedge CLK);
      t++;
    end
    chk("send_in_ready", in_ready, 1);
    in_valid = 1'b1;
    digits   = b;
    @(negedge CLK);
    in_valid = 1'b0;
    digits   = {$urandom, $urandom};
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 50) begin
      @(negedge CLK);
      lat++;
    end
    chk("out_valid_wait", out_valid, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    logic [BW-1:0] b;

    chk("model_123456789", ref_val(dec_bus(123456789)), 30'h75BCD15);
    chk("model_999999999", ref_val(dec_bus(999999999)), 30'h3B9AC9FF);
    b = '0;
    b[DIGW +: DIGW] = 5'h0A;
    chk("model_tens_0A_val", ref_val(b), 100);
    chk("model_tens_0A_bad", ref_bad(b), 1);

    // reset held for two edges
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_bin_out", bin_out, 0);
    chk("rst_err", err, 0);
    chk("rst_in_ready", in_ready, 1);

    // zero snapshot, latency and single-cycle valid
    out_ready = 1'b1;
    send(dec_bus(0));
    wait_valid(lat);
    chk("latency_edges", lat - 1, NDIG);
    chk("zero_bin", bin_out, 0);
    @(negedge CLK);
    chk("valid_one_cycle", out_valid, 0);

    send(dec_bus(123456789));
    wait_valid(lat);
    chk("bin_123456789", bin_out, 30'h75BCD15);
    chk("err_123456789", err, 0);
    @(negedge CLK);

    send(dec_bus(999999999));
    wait_valid(lat);
    chk("bin_999999999", bin_out, 30'h3B9AC9FF);
    chk("err_999999999", err, 0);
    @(negedge CLK);

    // backpressure: result held, new snapshot refused
    out_ready = 1'b0;
    send(dec_bus(555));
    wait_valid(lat);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      digits   = dec_bus(777);
      @(negedge CLK);
      chk("stall_bin", bin_out, 555);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_out_valid", out_valid, 1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge CLK);
    chk("post_hs_out_valid", out_valid, 0);
    chk("post_hs_in_ready", in_ready, 1);
    chk("post_hs_bin_kept", bin_out, 555);
    send(dec_bus(314159265));
    wait_valid(lat);
    chk("bin_314159265", bin_out, 314159265);
    @(negedge CLK);

    // reset on the 4th conversion edge
    send(dec_bus(123456789));
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_bin", bin_out, 0);
    chk("midrst_in_ready", in_ready, 1);
    send(dec_bus(42));
    wait_valid(lat);
    chk("bin_42", bin_out, 42);
    @(negedge CLK);

    // out-of-range digits
    b = '0;
    b[DIGW +: DIGW] = 5'h0A;
    send(b);
    wait_valid(lat);
`ifdef ERR_CHECK_EN
    chk("tens_0A_err", err, 1);
    chk("tens_0A_bin", bin_out, 0);
`else
    chk("tens_0A_err", err, 0);
    chk("tens_0A_bin", bin_out, 100);
`endif
    @(negedge CLK);

    b = '0;
    b[DIGW +: DIGW] = 5'h13;
    send(b);
    wait_valid(lat);
`ifdef ERR_CHECK_EN
    chk("tens_13_err", err, 1);
    chk("tens_13_bin", bin_out, 0);
`else
    chk("tens_13_err", err, 0);
    chk("tens_13_bin", bin_out, 30);
`endif
    @(negedge CLK);

    b = '0;
    b[2*DIGW +: DIGW] = 5'h0F;
    send(b);
    wait_valid(lat);
`ifdef ERR_CHECK_EN
    chk("hund_0F_err", err, 1);
`else
    chk("hund_0F_bin", bin_out, 1500);
`endif
    @(negedge CLK);

    // randomized traffic, checked every cycle by the model
    for (int c = 0; c < 4000; c++) begin
      RST       = ($urandom_range(0, 599) == 0);
      in_valid  = ($urandom_range(0, 2) == 0);
      digits    = rand_bus();
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge CLK);
    end
    RST       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (20) @(negedge CLK);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
